// File: rtl/regfile_mp_if.sv
// Bundles the read, write-back, reservation and status signals of regfile_mp.
// The master side (decode/write-back logic) drives addresses and data; the slave is the register file.
interface regfile_mp_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 3
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [NUM_RD*ADDR_W-1:0] A_Rd;
  logic [NUM_RD-1:0]        C_RdEn;
  logic [NUM_RD*DATA_W-1:0] D_Rd;
  logic [NUM_RD-1:0]        C_RdValid;

  logic                     C_WrEn0;
  logic [ADDR_W-1:0]        A_Wr0;
  logic [DATA_W-1:0]        D_Wr0;
  logic                     C_WrEn1;
  logic [ADDR_W-1:0]        A_Wr1;
  logic [DATA_W-1:0]        D_Wr1;

  logic                     C_Reserve;
  logic [ADDR_W-1:0]        A_Reserve;
  logic [DEPTH-1:0]         D_Pending;
  logic                     C_Stall;
  logic                     C_Err;

  modport master (
    output A_Rd, C_RdEn, C_WrEn0, A_Wr0, D_Wr0, C_WrEn1, A_Wr1, D_Wr1,
           C_Reserve, A_Reserve,
    input  D_Rd, C_RdValid, D_Pending, C_Stall, C_Err
  );

  modport slave (
    input  A_Rd, C_RdEn, C_WrEn0, A_Wr0, D_Wr0, C_WrEn1, A_Wr1, D_Wr1,
           C_Reserve, A_Reserve,
    output D_Rd, C_RdValid, D_Pending, C_Stall, C_Err
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: registered reads with same-cycle write bypass,
// two write-back ports (port 1 wins) and a pending-load scoreboard that drives the stall.
module regfile_mp #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 3,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q [NUM_RD];
  logic [NUM_RD-1:0] rd_valid_q;
  logic [DEPTH-1:0]  pending_q, pending_d;
  logic              err_q, err_d;

  logic [DEPTH-1:0]  wr0_dec, wr1_dec, clr_dec, res_dec;
  logic [ADDR_W-1:0] rd_addr [NUM_RD];
  logic [DATA_W-1:0] rd_byp  [NUM_RD];
  logic [NUM_RD-1:0] hazard;

  // Register 0 is hard-wired when ZERO_REG is set: writes and reservations to it vanish.
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  always_comb begin
    wr0_dec = '0;
    wr1_dec = '0;
    clr_dec = '0;
    res_dec = '0;
    if (bus.C_WrEn0 && !is_zero_reg(bus.A_Wr0))
      wr0_dec = DEPTH'(1) << bus.A_Wr0;
    if (bus.C_WrEn1 && !is_zero_reg(bus.A_Wr1))
      wr1_dec = DEPTH'(1) << bus.A_Wr1;
    if (bus.C_WrEn1)
      clr_dec = DEPTH'(1) << bus.A_Wr1;
    if (bus.C_Reserve && !is_zero_reg(bus.A_Reserve))
      res_dec = DEPTH'(1) << bus.A_Reserve;
  end

  // A reservation landing on the register being cleared is a new load and wins.
  always_comb begin
    pending_d = (pending_q & ~clr_dec) | res_dec;
    err_d     = (bus.C_WrEn0 && pending_q[bus.A_Wr0]) ||
                (|(res_dec & pending_q & ~clr_dec));
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    assign rd_addr[i] = bus.A_Rd[i*ADDR_W +: ADDR_W];

    // The hazard term uses only addresses, enables and scoreboard state, never write data.
    assign hazard[i] = bus.C_RdEn[i] && pending_q[rd_addr[i]] &&
                       !(bus.C_WrEn1 && (bus.A_Wr1 == rd_addr[i]));

    always_comb begin
      rd_byp[i] = mem_q[rd_addr[i]];
      if (is_zero_reg(rd_addr[i]))
        rd_byp[i] = '0;
      else if (bus.C_WrEn1 && (bus.A_Wr1 == rd_addr[i]))
        rd_byp[i] = bus.D_Wr1;
      else if (bus.C_WrEn0 && (bus.A_Wr0 == rd_addr[i]))
        rd_byp[i] = bus.D_Wr0;
    end

    assign bus.D_Rd[i*DATA_W +: DATA_W] = rd_data_q[i];
  end

  // NOTE: the array is reset on purpose -- software relies on every register reading 0
  // after reset, so this storage cannot be mapped to a reset-less RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) mem_q[r] <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (wr1_dec[r])      mem_q[r] <= bus.D_Wr1;
        else if (wr0_dec[r]) mem_q[r] <= bus.D_Wr0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_RD; i++) rd_data_q[i] <= '0;
      rd_valid_q <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (bus.C_RdEn[i]) begin
          rd_data_q[i]  <= rd_byp[i];
          rd_valid_q[i] <= !hazard[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end

  assign bus.C_RdValid = rd_valid_q;
  assign bus.D_Pending = pending_q;
  assign bus.C_Stall   = |hazard;
  assign bus.C_Err     = err_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a behavioural register-file model is compared every
// falling edge, and literal expectations from the usage scenarios pin that model.
module tb_regfile_mp;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 3;
  localparam int DEPTH = 1 << AW;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an array of integers plus a set of registers awaiting loads.
  int unsigned m_reg [DEPTH];
  bit          m_pend [DEPTH];
  int unsigned m_rd [NR];
  bit          m_val [NR];
  bit          m_err;

  initial begin
    for (int r = 0; r < DEPTH; r++) begin m_reg[r] = 0; m_pend[r] = 0; end
    for (int i = 0; i < NR; i++) begin m_rd[i] = 0; m_val[i] = 0; end
    m_err = 0;
  end

  function automatic int unsigned rd_addr(input int p);
    return int'(bus.A_Rd[p*AW +: AW]);
  endfunction

  // A read is stale if its register awaits a load the memory port is not delivering now.
  function automatic bit load_blocks(input int a);
    return m_pend[a] && !(bus.C_WrEn1 && int'(bus.A_Wr1) == a);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) begin m_reg[r] = 0; m_pend[r] = 0; end
      for (int i = 0; i < NR; i++) begin m_rd[i] = 0; m_val[i] = 0; end
      m_err = 0;
    end else begin
      int w0, w1, rv;
      w0 = int'(bus.A_Wr0);
      w1 = int'(bus.A_Wr1);
      rv = int'(bus.A_Reserve);
      for (int i = 0; i < NR; i++) begin
        if (bus.C_RdEn[i]) begin
          int a;
          a = rd_addr(i);
          if (a == 0)                    m_rd[i] = 0;
          else if (bus.C_WrEn1 && w1 == a) m_rd[i] = bus.D_Wr1;
          else if (bus.C_WrEn0 && w0 == a) m_rd[i] = bus.D_Wr0;
          else                           m_rd[i] = m_reg[a];
          m_val[i] = !load_blocks(a);
        end
      end
      m_err = (bus.C_WrEn0 && m_pend[w0]) ||
              (bus.C_Reserve && rv != 0 && load_blocks(rv));
      if (bus.C_WrEn0 && w0 != 0) m_reg[w0] = bus.D_Wr0;
      if (bus.C_WrEn1 && w1 != 0) m_reg[w1] = bus.D_Wr1;
      if (bus.C_WrEn1) m_pend[w1] = 0;
      if (bus.C_Reserve && rv != 0) m_pend[rv] = 1;
    end
  end

  always @(negedge clk) begin
    logic [DEPTH-1:0] pv;
    bit st;
    st = 0;
    for (int r = 0; r < DEPTH; r++) pv[r] = m_pend[r];
    for (int i = 0; i < NR; i++) begin
      check($sformatf("model rd%0d", i), 32'(bus.D_Rd[i*DW +: DW]), m_rd[i]);
      check($sformatf("model valid%0d", i), 32'(bus.C_RdValid[i]), 32'(m_val[i]));
      if (bus.C_RdEn[i] && load_blocks(rd_addr(i))) st = 1;
    end
    check("model pending", 32'(bus.D_Pending), 32'(pv));
    check("model err", 32'(bus.C_Err), 32'(m_err));
    check("model stall", 32'(bus.C_Stall), 32'(st));
  end

  task automatic idle();
    bus.A_Rd = '0; bus.C_RdEn = '0;
    bus.C_WrEn0 = 1'b0; bus.A_Wr0 = '0; bus.D_Wr0 = '0;
    bus.C_WrEn1 = 1'b0; bus.A_Wr1 = '0; bus.D_Wr1 = '0;
    bus.C_Reserve = 1'b0; bus.A_Reserve = '0;
  endtask

  task automatic rd(input int p, input int a);
    bus.A_Rd[p*AW +: AW] = AW'(a);
    bus.C_RdEn[p] = 1'b1;
  endtask

  task automatic wr0(input int a, input int d);
    bus.C_WrEn0 = 1'b1; bus.A_Wr0 = AW'(a); bus.D_Wr0 = DW'(d);
  endtask

  task automatic wr1(input int a, input int d);
    bus.C_WrEn1 = 1'b1; bus.A_Wr1 = AW'(a); bus.D_Wr1 = DW'(d);
  endtask

  task automatic reserve(input int a);
    bus.C_Reserve = 1'b1; bus.A_Reserve = AW'(a);
  endtask

  // Let the current inputs take effect, then return 1 ns after the edge with inputs idle.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  function automatic logic [DW-1:0] d_rd(input int p);
    return bus.D_Rd[p*DW +: DW];
  endfunction

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Reset: get state non-zero, then pull reset mid-cycle.
    wr0(5, 'h1234); rd(0, 5); reserve(4);
    step();
    check("pre-reset rd0 bypass", 32'(d_rd(0)), 32'h1234);
    check("pre-reset pending r4", 32'(bus.D_Pending[4]), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("reset rd0", 32'(d_rd(0)), 32'h0);
    check("reset valid", 32'(bus.C_RdValid), 32'h0);
    check("reset pending", 32'(bus.D_Pending), 32'h0);
    check("reset err", 32'(bus.C_Err), 32'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    rd(0, 5);
    step();
    check("r5 after reset", 32'(d_rd(0)), 32'h0);
    check("r5 after reset valid", 32'(bus.C_RdValid[0]), 32'd1);

    // Both write ports on r3: port 1 wins on bypass and in the array.
    wr0(3, 'hAAAA); wr1(3, 'h5555); rd(0, 3);
    step();
    check("bypass prio r3", 32'(d_rd(0)), 32'h5555);
    rd(0, 3);
    step();
    check("array r3", 32'(d_rd(0)), 32'h5555);

    // Zero register ignores writes and reservations.
    wr0(0, 'hFFFF); wr1(0, 'hFFFF); reserve(0); rd(1, 0);
    step();
    check("r0 bypass read", 32'(d_rd(1)), 32'h0);
    check("r0 not pending", 32'(bus.D_Pending[0]), 32'd0);
    rd(0, 0);
    #1 check("r0 no stall", 32'(bus.C_Stall), 32'd0);
    step();
    check("r0 array read", 32'(d_rd(0)), 32'h0);

    // Load hazard on r7 resolved by the memory port write.
    reserve(7);
    step();
    check("r7 pending", 32'(bus.D_Pending[7]), 32'd1);
    rd(0, 7);
    #1 check("r7 stall", 32'(bus.C_Stall), 32'd1);
    step();
    check("r7 hazard valid", 32'(bus.C_RdValid[0]), 32'd0);
    wr1(7, 'hBEEF); rd(0, 7);
    #1 check("r7 fill no stall", 32'(bus.C_Stall), 32'd0);
    step();
    check("r7 fill data", 32'(d_rd(0)), 32'hBEEF);
    check("r7 fill valid", 32'(bus.C_RdValid[0]), 32'd1);
    check("r7 cleared", 32'(bus.D_Pending[7]), 32'd0);

    // Reserve and clear of r2 in the same cycle: stays pending, no error.
    reserve(2);
    step();
    wr1(2, 'h0042); reserve(2);
    step();
    check("r2 still pending", 32'(bus.D_Pending[2]), 32'd1);
    check("r2 collide no err", 32'(bus.C_Err), 32'd0);
    rd(2, 2);
    step();
    check("r2 data", 32'(d_rd(2)), 32'h0042);
    check("r2 hazard valid", 32'(bus.C_RdValid[2]), 32'd0);

    // Protocol errors on pending r9.
    reserve(9);
    step();
    wr0(9, 'h0011);
    step();
    check("r9 alu write err", 32'(bus.C_Err), 32'd1);
    check("r9 still pending", 32'(bus.D_Pending[9]), 32'd1);
    rd(1, 9);
    step();
    check("r9 err one cycle", 32'(bus.C_Err), 32'd0);
    check("r9 data", 32'(d_rd(1)), 32'h0011);
    reserve(9);
    step();
    check("r9 re-reserve err", 32'(bus.C_Err), 32'd1);
    step();
    check("r9 err drops", 32'(bus.C_Err), 32'd0);

    // Reset clears the outstanding r9 load; a later fill is an ordinary write.
    #2 rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    wr1(9, 'h0077);
    step();
    check("post-reset fill no err", 32'(bus.C_Err), 32'd0);
    wr0(9, 'h0078);
    step();
    check("post-reset alu no err", 32'(bus.C_Err), 32'd0);

    // Mixed traffic on a few registers, checked by the model every cycle.
    for (int n = 0; n < 80; n++) begin
      for (int p = 0; p < NR; p++)
        if ($urandom_range(0, 1) == 1) rd(p, int'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) == 0) wr0(int'($urandom_range(0, 3)), int'($urandom_range(0, 16'hFFFF)));
      if ($urandom_range(0, 2) == 0) wr1(int'($urandom_range(0, 3)), int'($urandom_range(0, 16'hFFFF)));
      if ($urandom_range(0, 3) == 0) reserve(int'($urandom_range(0, 3)));
      step();
    end

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parameterised multi-port register file with registered reads, two write ports (ALU and memory) that are bypassed into same-cycle reads, and a pending-load scoreboard. It sits in the decode stage in place of the single-configuration 16×16 register file: it feeds operands to the ALU/branch/store paths, takes write-back from the ALU and MDR, and raises a stall when an operand depends on an outstanding load.

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 4, register address width; DEPTH = 2^ADDR_W
- NUM_RD, 3, number of read ports (≥1)
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and reservations
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset
- A_Rd  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- C_RdEn  in  NUM_RD  read enable per port
- D_Rd  out  NUM_RD*DATA_W  registered read data, port i at [i*DATA_W +: DATA_W]
- C_RdValid  out  NUM_RD  registered; 1 = D_Rd[i] was captured without a load hazard
- C_WrEn0, A_Wr0, D_Wr0  in  1, ADDR_W, DATA_W  ALU write-back port
- C_WrEn1, A_Wr1, D_Wr1  in  1, ADDR_W, DATA_W  memory (MDR) write-back port; also clears pending
- C_Reserve, A_Reserve  in  1, ADDR_W  mark register as awaiting a load
- D_Pending  out  DEPTH  scoreboard vector, bit r = register r has an outstanding load
- C_Stall  out  1  combinational; 1 = an enabled read this cycle is hazarded
- C_Err  out  1  registered one-cycle pulse on scoreboard protocol violation

## Operation
- Storage: DEPTH×DATA_W array; writes take effect at posedge.
- Write priority: both ports enabled to the same address → port 1 value stored. Writes to address 0 dropped when ZERO_REG=1.
- Read capture: at posedge, for each i with C_RdEn[i]=1, D_Rd[i] ← (addr 0 and ZERO_REG) ? 0 : port-1 write data if C_WrEn1 and A_Wr1 matches : port-0 write data if C_WrEn0 and A_Wr0 matches : array. C_RdEn[i]=0 → D_Rd[i] and C_RdValid[i] hold.
- Hazard for port i: C_RdEn[i] and D_Pending[A_Rd[i]] and not (C_WrEn1 and A_Wr1 = A_Rd[i]). C_Stall = OR of hazards. Hazarded read still captures data; C_RdValid[i] ← 0, else ← 1.
- Scoreboard, per register r at posedge: set if C_Reserve and A_Reserve=r; else cleared if C_WrEn1 and A_Wr1=r; else hold. Reserve on same cycle as clear of the same r → stays set (new load). Reserve to 0 ignored when ZERO_REG=1.
- C_Err ← 1 for one cycle if: C_WrEn0 targets a pending register (write is still performed, pending unchanged), or C_Reserve targets an already-pending register not being cleared this cycle. Otherwise 0.

## Timing
- Reset (rst=0, asynchronous): array all 0, D_Rd all 0, C_RdValid all 0, D_Pending all 0, C_Err 0. Release synchronous to clk edge by integration; first capture on first posedge with rst=1.
- Read latency: 1 cycle from address/enable to D_Rd. Write-to-read: same-cycle via bypass, 0 extra cycles.
- C_Stall depends combinationally on A_Rd, C_RdEn, D_Pending, A_Wr1, C_WrEn1 only (no path from data inputs).
- Reset mid-operation clears pending loads; a later port-1 write to a cleared register is an ordinary write, no error.
- D_Pending reflects registered state only (not this cycle's reserve/clear).

## Test plan
- Reset: write 0x1234 to r5, assert rst=0 asynchronously mid-cycle → D_Rd, C_RdValid, D_Pending, C_Err all 0 immediately; read r5 after release → 0x0000.
- Bypass/priority: same cycle C_WrEn0 r3=0xAAAA, C_WrEn1 r3=0x5555, read r3 on port 0 → D_Rd[0]=0x5555 next cycle; read again next cycle → 0x5555 from array.
- Zero register: write 0xFFFF to r0 on both ports and reserve r0 → reads of r0 return 0x0000, D_Pending[0]=0, C_Stall=0.
- Load hazard: reserve r7; next cycle read r7 → C_Stall=1, C_RdValid=0; following cycle port-1 writes r7=0xBEEF while reading r7 → C_Stall=0, D_Rd=0xBEEF, C_RdValid=1, D_Pending[7]=0.
- Reserve+clear collision: r2 pending, same cycle C_WrEn1 r2=0x0042 and C_Reserve r2 → D_Pending[2] stays 1, C_Err=0, r2 holds 0x0042.
- Errors: r9 pending; C_WrEn0 r9=0x0011 → C_Err pulses 1 cycle, r9=0x0011, D_Pending[9]=1; C_Reserve r9 again → second C_Err pulse.
